// File: rtl/matrix_op_sequencer_if.sv
// matrix_op_sequencer_if: instruction handshake, register-file and ALU signals of the sequencer
interface matrix_op_sequencer_if;
  logic         instr_valid_in;
  logic [15:0]  instr_in;
  logic         instr_ready_out;
  logic         busy_out;
  logic         done_out;
  logic         mem_rd_en_out;
  logic [3:0]   mem_rd_addr_out;
  logic [255:0] mem_rd_data_in;
  logic         mem_wr_en_out;
  logic [3:0]   mem_wr_addr_out;
  logic [255:0] mem_wr_data_out;
  logic [3:0]   alu_opcode_out;
  logic [255:0] alu_a_out;
  logic [255:0] alu_b_out;
  logic [255:0] alu_result_in;
  modport master (
    output instr_valid_in, instr_in, mem_rd_data_in, alu_result_in,
    input  instr_ready_out, busy_out, done_out, mem_rd_en_out, mem_rd_addr_out,
           mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, alu_opcode_out, alu_a_out, alu_b_out
  );
  modport slave (
    input  instr_valid_in, instr_in, mem_rd_data_in, alu_result_in,
    output instr_ready_out, busy_out, done_out, mem_rd_en_out, mem_rd_addr_out,
           mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, alu_opcode_out, alu_a_out, alu_b_out
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: fetches operands, runs the ALU for ALU_LATENCY cycles, writes the result back
module matrix_op_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input logic clk_in,
  input logic rst_in,
  matrix_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, EXEC, WB} state_t;
  localparam logic [3:0] LAST = 4'(ALU_LATENCY - 1);
  state_t state, state_nx;
  logic [15:0] instr;
  logic [255:0] a, b, res;
  logic [3:0] cnt;
  logic nop, unary;
  assign nop = instr[15:12] == 4'd0;
  assign unary = instr[15:12] == 4'd5;
  always_ff @(posedge clk_in) state <= rst_in ? IDLE : state_nx;
  // read data arrives one cycle after its strobe, so A lands in RD_B (binary) or CAP (unary)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      instr <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && bus.instr_valid_in) instr <= bus.instr_in;
      if (state == RD_B || (state == CAP && unary)) a <= bus.mem_rd_data_in;
      if (state == CAP) b <= unary ? '0 : bus.mem_rd_data_in;
      cnt <= state == CAP ? LAST : state == EXEC ? cnt - 4'd1 : cnt;
      if (state == EXEC && cnt == 4'd0) res <= bus.alu_result_in;
    end
  end
  always_comb begin
    state_nx = state;
    bus.instr_ready_out = 1'b0;
    bus.busy_out = state != IDLE;
    bus.done_out = 1'b0;
    bus.mem_rd_en_out = 1'b0;
    bus.mem_rd_addr_out = '0;
    bus.mem_wr_en_out = 1'b0;
    bus.mem_wr_addr_out = '0;
    bus.mem_wr_data_out = '0;
    bus.alu_opcode_out = '0;
    bus.alu_a_out = '0;
    bus.alu_b_out = '0;
    case (state)
      IDLE: begin
        bus.instr_ready_out = 1'b1;
        if (bus.instr_valid_in) state_nx = bus.instr_in[15:12] == 4'd0 ? WB : RD_A;
      end
      RD_A: begin
        bus.mem_rd_en_out = 1'b1;
        bus.mem_rd_addr_out = instr[3:0];
        state_nx = unary ? CAP : RD_B;
      end
      RD_B: begin
        bus.mem_rd_en_out = 1'b1;
        bus.mem_rd_addr_out = instr[7:4];
        state_nx = CAP;
      end
      CAP: state_nx = EXEC;
      EXEC: begin
        bus.alu_opcode_out = instr[15:12];
        bus.alu_a_out = a;
        bus.alu_b_out = b;
        if (cnt == 4'd0) state_nx = WB;
      end
      WB: begin
        bus.done_out = 1'b1;
        bus.mem_wr_en_out = !nop;
        bus.mem_wr_addr_out = nop ? 4'd0 : instr[11:8];
        bus.mem_wr_data_out = nop ? '0 : res;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: drives two sequencers (latency 1 and 3) against a register-file/ALU environment
module tb_matrix_op_sequencer;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, init_we = 1'b0;
  logic [15:0] instr = '0;
  logic [3:0] init_addr = '0;
  logic [255:0] init_data = '0, last_wd = '0;
  int u = 0, passed = 0, total = 0;
  logic [255:0] rf [16];
  logic [255:0] rf_ref [16];
  logic [3:0] ex1 = '0, ex3 = '0;
  logic ready, busy, done, rd_en, wr_en;
  logic [3:0] rd_addr, wr_addr, opc;
  logic [255:0] wr_data, aa, bb;

  matrix_op_sequencer_if b1 ();
  matrix_op_sequencer_if b3 ();
  matrix_op_sequencer #(.ALU_LATENCY(1)) dut1 (.clk_in(clk), .rst_in(rst), .bus(b1.slave));
  matrix_op_sequencer #(.ALU_LATENCY(3)) dut3 (.clk_in(clk), .rst_in(rst), .bus(b3.slave));

  always #5 clk = ~clk;

  function automatic logic [255:0] alu_fn(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [15:0] x, y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = a[i*16 +: 16];
      y = b[i*16 +: 16];
      r[i*16 +: 16] = op == 4'd4 ? x + y : op == 4'd1 ? x - y :
                      op == 4'd5 ? a[((i % 4) * 4 + i / 4) * 16 +: 16] : x ^ y ^ {12'd0, op};
    end
    return r;
  endfunction

  // ALU model only yields the true result once operands have been held for the full latency
  assign b1.alu_result_in = ex1 == 4'd0 ? alu_fn(b1.alu_opcode_out, b1.alu_a_out, b1.alu_b_out)
                                        : ~alu_fn(b1.alu_opcode_out, b1.alu_a_out, b1.alu_b_out);
  assign b3.alu_result_in = ex3 == 4'd2 ? alu_fn(b3.alu_opcode_out, b3.alu_a_out, b3.alu_b_out)
                                        : ~alu_fn(b3.alu_opcode_out, b3.alu_a_out, b3.alu_b_out);
  assign b1.instr_valid_in = valid && u == 0;
  assign b3.instr_valid_in = valid && u != 0;
  assign b1.instr_in = instr;
  assign b3.instr_in = instr;

  always @(posedge clk) begin
    if (init_we) rf[init_addr] <= init_data;
    if (b1.mem_wr_en_out) rf[b1.mem_wr_addr_out] <= b1.mem_wr_data_out;
    if (b3.mem_wr_en_out) rf[b3.mem_wr_addr_out] <= b3.mem_wr_data_out;
    if (b1.mem_rd_en_out) b1.mem_rd_data_in <= rf[b1.mem_rd_addr_out];
    if (b3.mem_rd_en_out) b3.mem_rd_data_in <= rf[b3.mem_rd_addr_out];
    ex1 <= b1.alu_opcode_out != 4'd0 ? ex1 + 4'd1 : 4'd0;
    ex3 <= b3.alu_opcode_out != 4'd0 ? ex3 + 4'd1 : 4'd0;
  end

  always_comb begin
    ready = u != 0 ? b3.instr_ready_out : b1.instr_ready_out;
    busy = u != 0 ? b3.busy_out : b1.busy_out;
    done = u != 0 ? b3.done_out : b1.done_out;
    rd_en = u != 0 ? b3.mem_rd_en_out : b1.mem_rd_en_out;
    rd_addr = u != 0 ? b3.mem_rd_addr_out : b1.mem_rd_addr_out;
    wr_en = u != 0 ? b3.mem_wr_en_out : b1.mem_wr_en_out;
    wr_addr = u != 0 ? b3.mem_wr_addr_out : b1.mem_wr_addr_out;
    wr_data = u != 0 ? b3.mem_wr_data_out : b1.mem_wr_data_out;
    opc = u != 0 ? b3.alu_opcode_out : b1.alu_opcode_out;
    aa = u != 0 ? b3.alu_a_out : b1.alu_a_out;
    bb = u != 0 ? b3.alu_b_out : b1.alu_b_out;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s (unit %0d, instr %h): got %0h expected %0h", tag, u, instr, obs, exp);
  endtask

  task automatic set_rf(input logic [3:0] addr, input logic [255:0] d);
    @(negedge clk);
    init_we = 1'b1;
    init_addr = addr;
    init_data = d;
    @(negedge clk);
    init_we = 1'b0;
    rf_ref[addr] = d;
  endtask

  task automatic run(input int unit, input logic [15:0] ins, input bit hold);
    int lat, exp_done, exp_rd, w, nrd, nwr, ndone, nex, bad, k_done, k_wr, k_rdy, k_ex, rd_log;
    bit nop, un;
    logic [255:0] ea, eb, er;
    logic [3:0] wa;
    lat = unit != 0 ? 3 : 1;
    nop = ins[15:12] == 4'd0;
    un = ins[15:12] == 4'd5;
    exp_done = nop ? 1 : un ? 3 + lat : 4 + lat;
    exp_rd = nop ? 0 : un ? 20 + ins[3:0] : (20 + ins[3:0]) * 100 + 40 + ins[7:4];
    ea = nop ? '0 : rf_ref[ins[3:0]];
    eb = (nop || un) ? '0 : rf_ref[ins[7:4]];
    er = alu_fn(ins[15:12], ea, eb);
    w = 0; nrd = 0; nwr = 0; ndone = 0; nex = 0; bad = 0;
    k_done = 0; k_wr = 0; k_rdy = 0; k_ex = 0; rd_log = 0; wa = '0;
    u = unit;
    #1;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 256'(w < 50), 256'(1));
    valid = 1'b1;
    instr = ins;
    @(posedge clk);
    for (int k = 1; k <= 40 && k_rdy == 0; k++) begin
      @(negedge clk);
      if (!hold) valid = 1'b0;
      if (rd_en) begin
        nrd++;
        rd_log = rd_log * 100 + k * 20 + int'(rd_addr);
      end else if (rd_addr != 4'd0) bad++;
      if (opc != 4'd0) begin
        nex++;
        if (k_ex == 0) k_ex = k;
        if (aa !== ea || bb !== eb) bad++;
      end else if (aa != '0 || bb != '0) bad++;
      if (done) begin
        ndone++;
        k_done = k;
      end
      if (wr_en) begin
        nwr++;
        k_wr = k;
        wa = wr_addr;
        last_wd = wr_data;
      end
      if (busy === ready) bad++;
      if (ready) k_rdy = k;
    end
    chk("rd_seq", rd_log, exp_rd);
    chk("first_exec", k_ex, nop ? 0 : un ? 3 : 4);
    chk("exec_len", nex, nop ? 0 : lat);
    chk("done_at", k_done, exp_done);
    chk("done_pulses", ndone, 1);
    chk("writes", nwr, nop ? 0 : 1);
    if (!nop) begin
      chk("wr_at", k_wr, exp_done);
      chk("wr_addr", wa, ins[11:8]);
      chk("wr_data", last_wd, er);
      rf_ref[ins[11:8]] = er;
    end
    chk("ready_at", k_rdy, exp_done + 1);
    chk("stable_and_idle_zero", bad, 0);
  endtask

  task automatic mid_reset();
    int n;
    n = 0;
    u = 1;
    #1;
    valid = 1'b1;
    instr = 16'h1012;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    chk("mid_exec_opcode", opc, 4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ctrl", {ready, busy, done, rd_en, rd_addr, wr_en, wr_addr, opc}, {1'b1, 16'd0});
    chk("abort_data", aa | bb | wr_data, '0);
    repeat (8) begin
      @(negedge clk);
      if (done || wr_en || busy) n++;
    end
    chk("abort_no_wb", n, 0);
  endtask

  initial begin
    logic [255:0] d;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      u = i;
      #1;
      chk("reset_ctrl", {ready, busy, done, rd_en, rd_addr, wr_en, wr_addr, opc}, {1'b1, 16'd0});
      chk("reset_data", aa | bb | wr_data, '0);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      set_rf(4'(i), d);
    end
    set_rf(4'd1, {16{16'h0001}});
    set_rf(4'd2, {16{16'h0002}});
    run(0, 16'h4312, 1'b0);
    chk("add_all_three", last_wd, {16{16'h0003}});
    run(0, 16'h5700, 1'b0);
    run(1, 16'h5700, 1'b0);
    run(0, 16'h0FFF, 1'b0);
    run(1, 16'h1012, 1'b0);
    run(1, 16'h4312, 1'b0);
    run(0, 16'h4111, 1'b1);
    run(0, 16'h4111, 1'b0);
    run(1, 16'h4111, 1'b1);
    run(1, 16'h4111, 1'b0);
    mid_reset();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      run(int'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 1)));
    end
    valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) chk("rf_final", rf[i], rf_ref[i]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
